alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched.sv | 123 ++++++++++++
 tb/tb_alu_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler in front of one shared multi-cycle ALU.
// Optional divide/multiply-by-zero rejection is enabled by defining ALU_SCHED_DIVZERO_CHK_EN.
module alu_sched #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_funct,
  input  logic [15:0] req0_op1,
  input  logic [15:0] req0_op2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_funct,
  input  logic [15:0] req1_op1,
  input  logic [15:0] req1_op2,
  output logic [3:0]  alu_funct,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_remainder,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [15:0] rsp_remainder,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  state_t      state;
  logic        prio;
  logic [3:0]  cnt;
  logic        gnt0, gnt1, xfer;
  logic [3:0]  in_funct;
  logic [15:0] in_op1, in_op2;
  logic        legal, reject;

  // prio picks requester 1 on contention when set
  assign gnt0 = req0_valid & (~req1_valid | ~prio);
  assign gnt1 = req1_valid & (~req0_valid | prio);

  assign req0_ready = rst & (state == IDLE) & gnt0;
  assign req1_ready = rst & (state == IDLE) & gnt1;
  assign xfer       = req0_ready | req1_ready;
  assign busy       = (state != IDLE);

  assign in_funct = gnt1 ? req1_funct : req0_funct;
  assign in_op1   = gnt1 ? req1_op1   : req0_op1;
  assign in_op2   = gnt1 ? req1_op2   : req0_op2;

  always_comb begin
    legal = 1'b0;
    case (in_funct)
      4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0111, 4'b1000: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

`ifdef ALU_SCHED_DIVZERO_CHK_EN
  assign reject = ~legal | (((in_funct == 4'b0100) | (in_funct == 4'b0101)) & (in_op2 == 16'd0));
`else
  assign reject = ~legal;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      prio          <= 1'b0;
      cnt           <= 4'd0;
      alu_funct     <= 4'd0;
      alu_op1       <= 16'd0;
      alu_op2       <= 16'd0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= 16'd0;
      rsp_remainder <= 16'd0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          alu_funct <= in_funct;
          alu_op1   <= in_op1;
          alu_op2   <= in_op2;
          rsp_id    <= gnt1;
          if (reject) begin
            rsp_err       <= 1'b1;
            rsp_result    <= 16'd0;
            rsp_remainder <= 16'd0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else begin
            cnt   <= LAT4;
            state <= WAIT;
          end
        end
        // capture on the cycle the count expires, so WAIT lasts exactly ALU_LAT cycles
        WAIT: if (cnt <= 4'd1) begin
          cnt           <= 4'd0;
          rsp_result    <= alu_result;
          rsp_remainder <= alu_remainder;
          rsp_err       <= 1'b0;
          rsp_valid     <= 1'b1;
          state         <= RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          prio      <= ~rsp_id;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: directed vectors push expectations, a monitor pops on each response handshake.
module tb_alu_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_funct, req1_funct, alu_funct;
  logic [15:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [15:0] alu_op1, alu_op2, alu_result, alu_remainder;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [15:0] rsp_result, rsp_remainder;

  alu_sched #(.ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct(req0_funct),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct(req1_funct),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .alu_funct(alu_funct), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_remainder(alu_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Reference ALU; div-by-zero returns a recognisable marker
  always_comb begin
    alu_result    = 16'hBEEF;
    alu_remainder = 16'h0000;
    case (alu_funct)
      4'b0000: alu_result = alu_op1 + alu_op2;
      4'b0001: alu_result = alu_op1 - alu_op2;
      4'b0100: alu_result = 16'($signed(alu_op1) * $signed(alu_op2));
      4'b0101: if (alu_op2 == 16'd0) begin
        alu_result    = 16'hDEAD;
        alu_remainder = 16'h0007;
      end else begin
        alu_result    = 16'($signed(alu_op1) / $signed(alu_op2));
        alu_remainder = 16'($signed(alu_op1) % $signed(alu_op2));
      end
      4'b0111: alu_result = alu_op1;
      4'b1000: begin alu_result = alu_op2; alu_remainder = alu_op1; end
      default: alu_result = 16'hBEEF;
    endcase
  end

  // Second instance with ALU_LAT=4 for the mid-WAIT reset case
  logic        l_rst, l_req0_valid, l_req0_ready, l_req1_ready;
  logic [3:0]  l_req0_funct, l_alu_funct;
  logic [15:0] l_req0_op1, l_req0_op2, l_alu_op1, l_alu_op2, l_rsp_result, l_rsp_remainder;
  logic        l_rsp_valid, l_rsp_id, l_rsp_err, l_busy;

  alu_sched #(.ALU_LAT(4)) u_lat4 (
    .clk(clk), .rst(l_rst),
    .req0_valid(l_req0_valid), .req0_ready(l_req0_ready), .req0_funct(l_req0_funct),
    .req0_op1(l_req0_op1), .req0_op2(l_req0_op2),
    .req1_valid(1'b0), .req1_ready(l_req1_ready), .req1_funct(4'd0),
    .req1_op1(16'd0), .req1_op2(16'd0),
    .alu_funct(l_alu_funct), .alu_op1(l_alu_op1), .alu_op2(l_alu_op2),
    .alu_result(l_alu_op1 + l_alu_op2), .alu_remainder(16'd0),
    .rsp_valid(l_rsp_valid), .rsp_ready(1'b1), .rsp_id(l_rsp_id),
    .rsp_result(l_rsp_result), .rsp_remainder(l_rsp_remainder), .rsp_err(l_rsp_err),
    .busy(l_busy)
  );

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic [15:0] rem;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: every accepted response must match the oldest expectation
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d res=%h rem=%h err=%0d, required no response",
                 rsp_id, rsp_result, rsp_remainder, rsp_err);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_result, rsp_remainder, rsp_err} !== e) begin
          errors++;
          $display("FAIL rsp_match: got id=%0d res=%h rem=%h err=%0d, required id=%0d res=%h rem=%h err=%0d",
                   rsp_id, rsp_result, rsp_remainder, rsp_err, e.id, e.res, e.rem, e.err);
        end
      end
    end
  end

  // At most one ready at a time
  always @(negedge clk) begin
    if (req0_ready && req1_ready) begin
      checks++;
      errors++;
      $display("FAIL one_ready: got both readies high, required at most one");
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic set_req(input logic id, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    if (id) begin req1_valid = 1'b1; req1_funct = f; req1_op1 = a; req1_op2 = b; end
    else    begin req0_valid = 1'b1; req0_funct = f; req0_op1 = a; req0_op2 = b; end
  endtask

  task automatic issue(input logic id, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [15:0] erm, input logic ee);
    bit ok = 0;
    @(posedge clk); #1;
    set_req(id, f, a, b);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        sb.push_back('{id: id, res: er, rem: erm, err: ee});
        ok = 1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got no ready for req%0d, required a grant", id);
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Both requesters valid together; grants must come out in order 0 then 1
  task automatic contend(input exp_t e0, input logic [3:0] f0, input logic [15:0] a0, input logic [15:0] b0,
                         input exp_t e1, input logic [3:0] f1, input logic [15:0] a1, input logic [15:0] b1);
    int n = 0;
    logic [1:0] ord = 2'b11;
    @(posedge clk); #1;
    set_req(1'b0, f0, a0, b0);
    set_req(1'b1, f1, a1, b1);
    for (int c = 0; c < 60 && n < 2; c++) begin
      @(negedge clk);
      if (req0_ready && req0_valid) begin
        sb.push_back(e0); ord[n] = 1'b0; n++;
        @(posedge clk); #1 req0_valid = 1'b0;
      end else if (req1_ready && req1_valid) begin
        sb.push_back(e1); ord[n] = 1'b1; n++;
        @(posedge clk); #1 req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("grant_count", 64'(n), 64'd2);
    check("grant_order", 64'(ord), 64'b10);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    bit ok;
    logic seen;
    rst = 1'b0; l_rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_funct = 4'd0; req0_op1 = 16'd0; req0_op2 = 16'd0;
    req1_funct = 4'd0; req1_op1 = 16'd0; req1_op2 = 16'd0;
    l_req0_valid = 1'b0; l_req0_funct = 4'd0; l_req0_op1 = 16'd0; l_req0_op2 = 16'd0;

    // Reset state with requesters valid: everything low
    @(negedge clk);
    check("reset_outputs",
          64'({rsp_valid, rsp_id, rsp_result, rsp_remainder, rsp_err, alu_funct, busy, req0_ready, req1_ready}),
          64'd0);
    check("reset_alu_ops", 64'({alu_op1, alu_op2}), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1; l_rst = 1'b1;

    // Contention from reset: 0,1,0,1
    contend('{id: 1'b0, res: 16'd8,    rem: 16'd0,    err: 1'b0}, 4'b0000, 16'd5, 16'd3,
            '{id: 1'b1, res: 16'hFFFE, rem: 16'd0,    err: 1'b0}, 4'b0001, 16'd3, 16'd5);
    contend('{id: 1'b0, res: 16'h5678, rem: 16'h1234, err: 1'b0}, 4'b1000, 16'h1234, 16'h5678,
            '{id: 1'b1, res: 16'h00AB, rem: 16'd0,    err: 1'b0}, 4'b0111, 16'h00AB, 16'h0000);
    drain();

    // Single add: WAIT one cycle, then RESP
    issue(1'b0, 4'b0000, 16'd5, 16'd3, 16'd8, 16'd0, 1'b0);
    @(negedge clk);
    check("add_wait_cycle", 64'({rsp_valid, busy, alu_funct}), 64'({1'b0, 1'b1, 4'b0000}));
    @(negedge clk);
    check("add_resp_cycle", 64'({rsp_valid, busy}), 64'b11);
    drain();

    // Signed divide with remainder
    issue(1'b1, 4'b0101, 16'd7, 16'd2, 16'd3, 16'd1, 1'b0);
    drain();

    // Illegal code: RESP right after accept
    issue(1'b1, 4'b0011, 16'd9, 16'd9, 16'd0, 16'd0, 1'b1);
    @(negedge clk);
    check("illegal_direct_resp", 64'({rsp_valid, rsp_err}), 64'b11);
    drain();

    // Divide by zero
`ifdef ALU_SCHED_DIVZERO_CHK_EN
    issue(1'b0, 4'b0101, 16'd7, 16'd0, 16'd0, 16'd0, 1'b1);
`else
    issue(1'b0, 4'b0101, 16'd7, 16'd0, 16'hDEAD, 16'h0007, 1'b0);
`endif
    drain();

    // Backpressure: response held, other requester waits
    rsp_ready = 1'b0;
    issue(1'b0, 4'b0100, 16'hFFF9, 16'd6, 16'hFFD6, 16'd0, 1'b0);
    @(posedge clk); #1;
    set_req(1'b1, 4'b0000, 16'd1, 16'd1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    check("bp_rsp_valid", 64'(ok), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold",
            64'({rsp_valid, rsp_id, rsp_result, rsp_remainder, rsp_err, req0_ready, req1_ready}),
            64'({1'b1, 1'b0, 16'hFFD6, 16'h0000, 1'b0, 1'b0, 1'b0}));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    issue(1'b1, 4'b0000, 16'd1, 16'd1, 16'd2, 16'd0, 1'b0);
    drain();

    // Reset in the 2nd WAIT cycle of the ALU_LAT=4 instance
    @(posedge clk); #1;
    l_req0_valid = 1'b1; l_req0_funct = 4'b0000; l_req0_op1 = 16'd2; l_req0_op2 = 16'd2;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (l_req0_ready) ok = 1;
    end
    check("lat4_accept", 64'(ok), 64'd1);
    @(posedge clk); #1 l_req0_valid = 1'b0;
    @(posedge clk); #1;
    check("lat4_in_wait", 64'({l_busy, l_rsp_valid}), 64'b10);
    l_req0_valid = 1'b1;
    l_rst = 1'b0;
    #1;
    check("lat4_reset_outputs",
          64'({l_rsp_valid, l_rsp_id, l_rsp_result, l_rsp_remainder, l_rsp_err, l_alu_funct,
               l_busy, l_req0_ready, l_req1_ready}), 64'd0);
    check("lat4_reset_alu_ops", 64'({l_alu_op1, l_alu_op2}), 64'd0);
    @(posedge clk); #1 l_req0_valid = 1'b0;
    @(posedge clk); #1 l_rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (l_rsp_valid || l_busy) seen = 1'b1;
    end
    check("lat4_discarded", 64'(seen), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
